// File: rtl/w65_bus_pkg.sv
// Shared types and defaults for the 65C816-style bus initiator.
package w65_bus_pkg;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    typedef struct packed {
        logic        we;
        logic        vp;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    localparam int DEF_LO_CYC   = 4;
    localparam int DEF_HI_CYC   = 4;
    localparam int DEF_MAX_WAIT = 15;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/w65_phi_gen.sv
// Free-running PHI2 phase generator; strobes mark the final CLK of each phase.
module w65_phi_gen
    import w65_bus_pkg::*;
#(
    parameter int LO_CYC = DEF_LO_CYC,
    parameter int HI_CYC = DEF_HI_CYC
) (
    input  logic   CLK,
    input  logic   RESET,
    output logic   phi2,
    output phase_t phase,
    output logic   last_low,
    output logic   last_high
);
    localparam int CW = $clog2(max2(LO_CYC, HI_CYC) + 1);

    logic [CW-1:0] cnt;

    assign last_low  = (phase == PH_LOW)  && (cnt == CW'(LO_CYC - 1));
    assign last_high = (phase == PH_HIGH) && (cnt == CW'(HI_CYC - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase <= PH_LOW;
            phi2  <= 1'b0;
            cnt   <= '0;
        end else if (last_low) begin
            phase <= PH_HIGH;
            phi2  <= 1'b1;
            cnt   <= '0;
        end else if (last_high) begin
            phase <= PH_LOW;
            phi2  <= 1'b0;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/w65_bus_initiator.sv
// Bus-cycle initiator: turns client byte requests into PHI2 bus cycles,
// repeating whole cycles while RDY is low, up to a bounded wait count.
module w65_bus_initiator
    import w65_bus_pkg::*;
#(
    parameter int LO_CYC   = DEF_LO_CYC,
    parameter int HI_CYC   = DEF_HI_CYC,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_vp,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        PHI2,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        RWB,
    output logic        VDA,
    output logic        VPA,
    input  logic        RDY,
    input  logic        BE
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    phase_t        phase;
    logic          last_low, last_high;
    txn_t          txn, req, next_txn;
    logic          active, next_active;
    logic [WW-1:0] wait_cnt;
    logic          timeout, done, stay, accept;
    logic          oe_r;

    w65_phi_gen #(
        .LO_CYC (LO_CYC),
        .HI_CYC (HI_CYC)
    ) u_phi (
        .CLK       (CLK),
        .RESET     (RESET),
        .phi2      (PHI2),
        .phase     (phase),
        .last_low  (last_low),
        .last_high (last_high)
    );

    assign req     = {req_we, req_vp, req_addr, req_wdata};
    assign timeout = (wait_cnt == WW'(MAX_WAIT));
    assign done    = active && (RDY || timeout);
    assign stay    = active && !RDY && !timeout;

    // Ready may coincide with completion so back-to-back cycles have no gap.
    assign req_ready   = last_high && (!active || RDY || timeout);
    assign accept      = req_valid && req_ready;
    assign next_active = accept || stay;
    assign next_txn    = accept ? req : txn;

    // BE releases the data bus without disturbing the cycle sequencing.
    assign D_oe = oe_r & BE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            txn       <= '0;
            active    <= 1'b0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            A         <= 16'h0000;
            D_out     <= 8'h00;
            oe_r      <= 1'b0;
            RWB       <= 1'b1;
            VDA       <= 1'b0;
            VPA       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (last_high) begin
                if (done) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= !RDY;
                    rsp_rdata <= (RDY && !txn.we) ? D_in : 8'h00;
                end
                wait_cnt <= stay ? wait_cnt + WW'(1) : '0;
                active   <= next_active;
                txn      <= next_txn;
                // Entering PH_LOW: a repeated cycle re-presents the same address.
                if (next_active) begin
                    A     <= next_txn.addr[15:0];
                    D_out <= next_txn.addr[23:16];
                    oe_r  <= 1'b1;
                    RWB   <= ~next_txn.we;
                    VDA   <= ~next_txn.vp;
                    VPA   <= next_txn.vp;
                end else begin
                    D_out <= 8'h00;
                    oe_r  <= 1'b0;
                    RWB   <= 1'b1;
                    VDA   <= 1'b0;
                    VPA   <= 1'b0;
                end
            end else if (phase == PH_LOW && last_low && active) begin
                if (txn.we) begin
                    D_out <= txn.wdata;
                    oe_r  <= 1'b1;
                end else begin
                    oe_r  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_w65_bus_initiator.sv
// Directed bench for w65_bus_initiator with default timing (4/4 CLKs, 15 waits).
module tb_w65_bus_initiator;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_vp = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        PHI2;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in = 8'h0;
    logic        RWB, VDA, VPA;
    logic        RDY = 1'b1;
    logic        BE = 1'b1;

    int errors = 0;
    int checks = 0;

    logic        nxt_we, nxt_vp;
    logic [23:0] nxt_addr;
    logic [7:0]  nxt_wd;

    always #5 CLK = ~CLK;

    w65_bus_initiator dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vp(req_vp),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PHI2(PHI2), .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .RWB(RWB), .VDA(VDA), .VPA(VPA), .RDY(RDY), .BE(BE)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (!req_ready && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("req_ready_seen", {63'h0, req_ready}, 64'h1);
    endtask

    // k counts CLK edges since the accepting edge; bus cycle b completes at edge 8b+8.
    task automatic run(input logic we, input logic vp, input logic [23:0] addr,
                       input logic [7:0] wd, input logic [7:0] din, input int nlow,
                       input bit pre_acc, input bit chain, input logic be);
        int   ncyc;
        int   fin;
        logic hi, exp_oe;
        logic [7:0] exp_d;
        ncyc = (nlow > 15) ? 16 : nlow + 1;
        fin  = ncyc * 8;
        BE   = be;
        D_in = din;
        if (!pre_acc) begin
            req_we = we; req_vp = vp; req_addr = addr; req_wdata = wd;
            req_valid = 1'b1;
            RDY = 1'b1;
            wait_ready();
        end
        for (int k = pre_acc ? 1 : 0; k <= fin; k++) begin
            @(negedge CLK);
            if (k == 0) req_valid = 1'b0;
            if (k < fin) begin
                hi     = (k % 8) >= 4;
                exp_oe = be & (!hi | we);
                exp_d  = (hi && we) ? wd : addr[23:16];
                chk("bus", {A, D_oe, RWB, VDA, VPA, PHI2, rsp_valid, (D_oe ? D_out : 8'h00)},
                    {addr[15:0], exp_oe, ~we, ~vp, vp, hi, 1'b0, (exp_oe ? exp_d : 8'h00)});
                RDY = ((k >> 3) >= nlow);
                if (chain && k == fin - 1) begin
                    req_we = nxt_we; req_vp = nxt_vp; req_addr = nxt_addr; req_wdata = nxt_wd;
                    req_valid = 1'b1;
                    #1;
                    chk("ready_at_done", {63'h0, req_ready}, 64'h1);
                end
            end else begin
                chk("rsp", {rsp_valid, rsp_err, rsp_rdata},
                    {1'b1, ((nlow > 15) ? 1'b1 : 1'b0), (((nlow <= 15) && !we) ? din : 8'h00)});
                if (chain) begin
                    req_valid = 1'b0;
                end else begin
                    chk("idle_bus", {A, D_oe, RWB, VDA, VPA, D_out},
                        {addr[15:0], 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
                    @(negedge CLK);
                    chk("rsp_pulse", {63'h0, rsp_valid}, 64'h0);
                end
            end
        end
    endtask

    initial begin
        #12;
        chk("reset_vals", {PHI2, A, D_out, D_oe, RWB, VDA, VPA, req_ready, rsp_valid, rsp_rdata, rsp_err},
            {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0});
        @(negedge CLK);
        RESET = 1'b0;

        // Three idle bus cycles: PHI2 high on edges 4..7 of each 8.
        for (int j = 1; j <= 24; j++) begin
            @(negedge CLK);
            chk("idle", {PHI2, D_oe, RWB, VDA, VPA, rsp_valid},
                {((j % 8) >= 4), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        end

        run(1'b1, 1'b0, 24'h012345, 8'h5A, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        run(1'b0, 1'b1, 24'h00FFFC, 8'h00, 8'h34, 0, 1'b0, 1'b0, 1'b1);
        run(1'b0, 1'b0, 24'h001000, 8'h00, 8'hA7, 2, 1'b0, 1'b0, 1'b1);

        // Timeout, then two back-to-back requests accepted on completion edges.
        nxt_we = 1'b1; nxt_vp = 1'b0; nxt_addr = 24'h7F0010; nxt_wd = 8'hC3;
        run(1'b0, 1'b0, 24'h020304, 8'h00, 8'h55, 100, 1'b0, 1'b1, 1'b1);
        nxt_we = 1'b0; nxt_vp = 1'b0; nxt_addr = 24'h7F0011; nxt_wd = 8'h00;
        run(1'b1, 1'b0, 24'h7F0010, 8'hC3, 8'h00, 0, 1'b1, 1'b1, 1'b1);
        run(1'b0, 1'b0, 24'h7F0011, 8'h00, 8'h9E, 0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a write.
        req_we = 1'b1; req_vp = 1'b0; req_addr = 24'h0ABCDE; req_wdata = 8'hEE;
        req_valid = 1'b1;
        RDY = 1'b1;
        wait_ready();
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_reset", {PHI2, A, D_out, D_oe, RWB, VDA, VPA, req_ready, rsp_valid, rsp_rdata, rsp_err},
            {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0});
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge CLK);
            chk("no_rsp_after_reset", {63'h0, rsp_valid}, 64'h0);
        end

        run(1'b1, 1'b0, 24'h000200, 8'h11, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        run(1'b0, 1'b0, 24'h00ABCD, 8'h00, 8'h3C, 0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/w65_bus_initiator.md
# w65_bus_initiator

Bus-cycle initiator for the 65C816-style external bus: generates PHI2 from the board clock and drives address, multiplexed bank/data, RWB, VDA and VPA to an attached memory/IO responder. It is the master-side counterpart of the FPGA's responder logic. On the FPGA side, an internal client (DMA engine or self-test sequencer) issues byte read/write requests through a valid/ready handshake. The block honours RDY wait states with a bounded timeout.

## Interface
- LO_CYC, 4: CLK cycles per PHI2-low phase (≥1)
- HI_CYC, 4: CLK cycles per PHI2-high phase (≥1)
- MAX_WAIT, 15: maximum RDY-low repeats before a cycle is aborted (≥1)

- CLK  in  1  system clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- req_valid  in  1  client request valid
- req_ready  out  1  request accepted on this CLK edge when req_valid=1
- req_we  in  1  1 = write, 0 = read
- req_vp  in  1  1 = program fetch (VPA), 0 = data access (VDA)
- req_addr  in  24  {bank, address}
- req_wdata  in  8  write data
- rsp_valid  out  1  one-CLK completion pulse
- rsp_rdata  out  8  read data (0 for writes/errors)
- rsp_err  out  1  completion was a RDY timeout
- PHI2  out  1  generated bus clock
- A  out  16  address bus
- D_out  out  8  data/bank driven value
- D_oe  out  1  data-bus output enable
- D_in  in  8  data bus input
- RWB  out  1  1 = read, 0 = write
- VDA, VPA  out  1 each  cycle-type qualifiers
- RDY  in  1  responder ready; low = wait state
- BE  in  1  bus enable; low = release bus

## Operation
- Phase FSM has two states:
  - PH_LOW: PHI2=0, LO_CYC clocks.
  - PH_HIGH: PHI2=1, HI_CYC clocks.
  - Free-running, starting in PH_LOW after reset.
- Each PH_LOW+PH_HIGH pair is one bus cycle. It is either idle or carries the active transaction.
- Acceptance:
  - req_ready is high only on the last CLK of PH_HIGH, and only when no transaction is active or the active one completes on that edge.
  - req_ready is combinational on RDY and the wait count.
  - On req_valid&&req_ready the request is latched and becomes active from the next PH_LOW.
- Active cycle, PH_LOW:
  - A=addr[15:0].
  - D_out=addr[23:16], D_oe=1.
  - RWB=~we; VDA=~vp, VPA=vp.
- Active cycle, PH_HIGH:
  - Write: D_out=wdata, D_oe=1.
  - Read: D_oe=0.
- Completion is decided on the last CLK of PH_HIGH:
  - RDY=1: complete. rsp_valid=1 next CLK, rsp_rdata=D_in (reads) or 0, rsp_err=0.
  - RDY=0: wait count +1; the whole bus cycle repeats with identical A/bank/controls.
  - RDY=0 with wait count already MAX_WAIT: complete with rsp_err=1, rsp_rdata=0.
- Idle cycle:
  - A holds its last value, D_out=0, D_oe=0, RWB=1, VDA=VPA=0.
  - RDY is ignored.
- BE=0 forces D_oe=0 combinationally. The FSM and PHI2 keep running and transactions still complete. Top-level pads use BE to tri-state A/RWB.
- RESET mid-transaction aborts it with no response. The client must reissue.

## Timing
- Reset values:
  - PHI2=0, A=0, D_out=0, D_oe=0, RWB=1, VDA=VPA=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Phase PH_LOW, counters 0.
- All outputs except req_ready and gated D_oe are registered.
- PHI2 period = LO_CYC+HI_CYC CLKs. Phase changes on the CLK edge after the counter reaches LO_CYC-1 / HI_CYC-1.
- Bus signals change on the CLK edge that enters PH_LOW. D_out/D_oe change again on the edge entering PH_HIGH.
- Latency, accept to rsp_valid, with no waits: LO_CYC+HI_CYC CLKs. Each wait state adds LO_CYC+HI_CYC.
- Back-to-back: a new request can be accepted on the same edge as completion, so there are zero idle bus cycles.
- D_in and RDY are sampled on the final CLK edge of PH_HIGH. The responder must be stable by then.
- rsp_valid is a single CLK pulse; there is no backpressure, so the client must accept it.

## Structure
- Package w65_bus_pkg holds:
  - phase_t enum {PH_LOW, PH_HIGH}.
  - The transaction struct {we, vp, addr[23:0], wdata}.
  - Default LO_CYC/HI_CYC/MAX_WAIT constants.
- Sub-module w65_phi_gen: phase counter/FSM producing PHI2, phase, last_low and last_high strobes.
- The top holds the transaction register, wait counter, bus drivers and response logic.
- Counter widths: $clog2(max(LO_CYC,HI_CYC)+1) and $clog2(MAX_WAIT+1).

## Test plan
- Reset then idle for 3 bus cycles -> PHI2 toggles every 4 CLKs, VDA=VPA=0, RWB=1, D_oe=0, no rsp_valid.
- Write 0x5A to 0x01_2345 with RDY=1:
  - PH_LOW shows A=0x2345, D_out=0x01.
  - PH_HIGH shows D_out=0x5A, RWB=0, VDA=1.
  - rsp_valid 8 CLKs after accept.
- Read 0x00_FFFC with req_vp=1, responder returns 0x34 -> VPA=1, D_oe=0 in PH_HIGH, rsp_rdata=0x34.
- RDY held low for 2 cycles on a read -> 3 identical bus cycles, rsp_valid at 24 CLKs, rsp_err=0.
- RDY held low forever -> 16 bus cycles, then rsp_err=1, rsp_rdata=0. The next request is accepted on the same edge.
- Two requests with req_valid held high -> second accepted on first's completion edge, no idle cycle. RESET asserted mid-cycle -> all outputs at reset values asynchronously.
